// File: rtl/jt5205_player.sv
// ADPCM sample player for a JT5205-style decoder.
// Fetches bytes from ROM between start_addr and end_addr (inclusive, wrapping at 2^AW)
// and feeds one nibble to the decoder per qualified sample tick (cen & sample).
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   cen, sample        clock enable and sample-tick strobe; a tick is cen & sample
//   start, stop        one-cycle playback requests (stop wins)
//   start_addr         first byte address, latched on start
//   end_addr           last byte address (inclusive), latched on start
//   rom_addr, rom_cs   ROM byte address and read request
//   rom_data, rom_ok   ROM read data and its valid flag (only honoured while rom_cs=1)
//   din                nibble to the decoder
//   dec_rst            one-cycle decoder predictor clear at the start of playback
//   busy               playback active
//   done               one-cycle pulse at normal end of sample
//   underrun           one-cycle pulse when a tick arrives with no byte buffered
module jt5205_player #(
    parameter int unsigned AW         = 16,
    parameter bit          HIGH_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          sample,
    input  logic          start,
    input  logic          stop,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    output logic [3:0]    din,
    output logic          dec_rst,
    output logic          busy,
    output logic          done,
    output logic          underrun
);

    typedef enum logic [1:0] {StIdle, StFetch, StPlay} state_t;

    state_t        state;
    logic [AW-1:0] end_q;
    logic [7:0]    data_buf;
    logic          ptr_second;   // 0: next tick plays first nibble, 1: second nibble

    logic       tick;
    logic [3:0] nib_first;
    logic [3:0] nib_second;

    always_comb begin
        tick       = cen & sample;
        nib_first  = HIGH_FIRST ? data_buf[7:4] : data_buf[3:0];
        nib_second = HIGH_FIRST ? data_buf[3:0] : data_buf[7:4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            end_q      <= '0;
            data_buf   <= '0;
            ptr_second <= 1'b0;
            rom_addr   <= '0;
            rom_cs     <= 1'b0;
            din        <= 4'd0;
            dec_rst    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle
            dec_rst  <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
            if (stop) begin
                state  <= StIdle;
                rom_cs <= 1'b0;
                busy   <= 1'b0;
            end else if (start) begin
                // Restart is allowed from any state, including mid-fetch
                end_q    <= end_addr;
                rom_addr <= start_addr;
                state    <= StFetch;
                rom_cs   <= 1'b1;
                busy     <= 1'b1;
                dec_rst  <= 1'b1;
            end else begin
                unique case (state)
                    StFetch: begin
                        if (rom_cs && rom_ok) begin
                            data_buf   <= rom_data;
                            ptr_second <= 1'b0;
                            state      <= StPlay;
                            rom_cs     <= 1'b0;
                        end
                        // A tick with nothing buffered is dropped, not replayed
                        if (tick) begin
                            underrun <= 1'b1;
                        end
                    end
                    StPlay: begin
                        if (tick) begin
                            if (!ptr_second) begin
                                din        <= nib_first;
                                ptr_second <= 1'b1;
                            end else begin
                                din <= nib_second;
                                if (rom_addr == end_q) begin
                                    state <= StIdle;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end else begin
                                    rom_addr <= rom_addr + 1'b1;
                                    state    <= StFetch;
                                    rom_cs   <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        // Idle: ticks are ignored
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jt5205_player.sv
// Bench for jt5205_player: two instances (high-nibble-first and low-nibble-first) share
// control stimulus, each with its own ROM responder. Expected nibbles are queued when a
// playback is launched and popped whenever din changes.
module tb_jt5205_player;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cen = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] end_addr = '0;
    logic          sample;
    logic          sample_auto = 1'b0;
    logic          sample_man = 1'b0;

    logic [AW-1:0] rom_addr_h, rom_addr_l;
    logic          rom_cs_h, rom_cs_l, rom_ok_h, rom_ok_l;
    logic [7:0]    rom_data_h, rom_data_l;
    logic [3:0]    din_h, din_l;
    logic          dec_rst_h, dec_rst_l, busy_h, busy_l, done_h, done_l;
    logic          underrun_h, underrun_l;

    assign sample = sample_auto | sample_man;

    always #5 clk = ~clk;

    jt5205_player #(.AW(AW), .HIGH_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .sample(sample), .start(start), .stop(stop),
        .start_addr(start_addr), .end_addr(end_addr), .rom_addr(rom_addr_h),
        .rom_cs(rom_cs_h), .rom_data(rom_data_h), .rom_ok(rom_ok_h), .din(din_h),
        .dec_rst(dec_rst_h), .busy(busy_h), .done(done_h), .underrun(underrun_h)
    );

    jt5205_player #(.AW(AW), .HIGH_FIRST(1'b0)) dut_lo (
        .clk(clk), .rst_n(rst_n), .cen(cen), .sample(sample), .start(start), .stop(stop),
        .start_addr(start_addr), .end_addr(end_addr), .rom_addr(rom_addr_l),
        .rom_cs(rom_cs_l), .rom_data(rom_data_l), .rom_ok(rom_ok_l), .din(din_l),
        .dec_rst(dec_rst_l), .busy(busy_l), .done(done_l), .underrun(underrun_l)
    );

    // ROM contents
    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        case (a)
            16'h0010: return 8'hA5;
            16'h0011: return 8'h3C;
            16'hFFFF: return 8'h12;
            16'h0000: return 8'h34;
            default:  return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // ROM responders: rom_ok rises rom_delay cycles after rom_cs
    int rom_delay = 2;
    int cnt_h = 0;
    int cnt_l = 0;
    always @(posedge clk) begin
        cnt_h <= rom_cs_h ? cnt_h + 1 : 0;
        cnt_l <= rom_cs_l ? cnt_l + 1 : 0;
    end
    assign rom_ok_h   = rom_cs_h && (cnt_h >= rom_delay);
    assign rom_ok_l   = rom_cs_l && (cnt_l >= rom_delay);
    assign rom_data_h = rom_byte(rom_addr_h);
    assign rom_data_l = rom_byte(rom_addr_l);

    // Periodic tick generator (tick_period = 0 disables it)
    int tick_period = 0;
    int tick_cnt = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tick_period > 0 && tick_cnt >= tick_period - 1) begin
                sample_auto = 1'b1;
                tick_cnt = 0;
            end else begin
                sample_auto = 1'b0;
                if (tick_period > 0) tick_cnt++;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard / monitor
    logic [3:0]  exp_h[$];
    logic [3:0]  exp_l[$];
    logic [15:0] fetch_addrs[$];
    logic [3:0]  prev_h = 4'd0;
    logic [3:0]  prev_l = 4'd0;
    logic        prev_cs_h = 1'b0;
    logic [15:0] prev_addr_h = '0;
    int done_cnt_h = 0, done_cnt_l = 0, under_cnt_h = 0, under_cnt_l = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_h = din_h;
            prev_l = din_l;
            prev_cs_h = 1'b0;
        end else begin
            if (din_h !== prev_h) begin
                if (exp_h.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL din_hi_unexpected: got %0h expected no change from %0h",
                             din_h, prev_h);
                end else chk("din_hi", din_h, exp_h.pop_front());
                prev_h = din_h;
            end
            if (din_l !== prev_l) begin
                if (exp_l.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL din_lo_unexpected: got %0h expected no change from %0h",
                             din_l, prev_l);
                end else chk("din_lo", din_l, exp_l.pop_front());
                prev_l = din_l;
            end
            if (done_h) begin
                done_cnt_h++;
                chk("done_with_busy_low", busy_h, 0);
            end
            if (done_l) done_cnt_l++;
            if (underrun_h) under_cnt_h++;
            if (underrun_l) under_cnt_l++;
            if (rom_cs_h && prev_cs_h) chk("rom_addr_stable", rom_addr_h, prev_addr_h);
            if (rom_cs_h && !prev_cs_h) fetch_addrs.push_back(rom_addr_h);
            prev_cs_h = rom_cs_h;
            prev_addr_h = rom_addr_h;
        end
    end

    typedef struct {
        logic [15:0] sa;
        logic [15:0] ea;
        int          delay;
        int          period;
        bit          exp_under;
    } vec_t;

    vec_t vecs[4];

    task automatic clear_counts();
        done_cnt_h = 0; done_cnt_l = 0; under_cnt_h = 0; under_cnt_l = 0;
        fetch_addrs.delete();
    endtask

    // Called at #1 after a rising edge
    task automatic run_vec(input vec_t v);
        int nbytes;
        logic [15:0] a;
        logic [7:0] b;
        bit fin;
        nbytes = int'(16'(v.ea - v.sa)) + 1;
        for (int i = 0; i < nbytes; i++) begin
            a = v.sa + 16'(i);
            b = rom_byte(a);
            exp_h.push_back(b[7:4]); exp_h.push_back(b[3:0]);
            exp_l.push_back(b[3:0]); exp_l.push_back(b[7:4]);
        end
        clear_counts();
        rom_delay = v.delay;
        tick_cnt = 0;
        tick_period = v.period;
        start_addr = v.sa; end_addr = v.ea; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("start_dec_rst", dec_rst_h, 1);
        chk("start_dec_rst_lo", dec_rst_l, 1);
        chk("start_busy", busy_h, 1);
        chk("start_rom_cs", rom_cs_h, 1);
        chk("start_rom_addr", rom_addr_h, v.sa);
        @(posedge clk); #1;
        chk("dec_rst_one_cycle", dec_rst_h, 0);
        fin = 1'b0;
        for (int c = 0; c < 6000 && !fin; c++) begin
            @(posedge clk); #1;
            if (!busy_h && !busy_l) fin = 1'b1;
        end
        chk("play_finished", fin, 1);
        tick_period = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("done_count_hi", done_cnt_h, 1);
        chk("done_count_lo", done_cnt_l, 1);
        chk("underrun_hi", under_cnt_h > 0, v.exp_under);
        chk("underrun_lo", under_cnt_l > 0, v.exp_under);
        chk("nibbles_left_hi", exp_h.size(), 0);
        chk("nibbles_left_lo", exp_l.size(), 0);
        chk("fetch_count", fetch_addrs.size(), nbytes);
        if (fetch_addrs.size() > 0) begin
            chk("first_fetch_addr", fetch_addrs[0], v.sa);
            chk("last_fetch_addr", fetch_addrs[fetch_addrs.size() - 1], v.ea);
        end
        chk("idle_rom_cs", rom_cs_h, 0);
        exp_h.delete(); exp_l.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bit fin;
        vecs[0] = '{16'h0010, 16'h0011, 2, 96, 1'b0};    // basic two-byte play
        vecs[1] = '{16'hFFFF, 16'h0000, 2, 96, 1'b0};    // address wrap
        vecs[2] = '{16'h0020, 16'h0020, 2, 20, 1'b0};    // single byte
        vecs[3] = '{16'h0030, 16'h0031, 200, 96, 1'b1};  // slow ROM, underruns

        // Reset values
        #12;
        chk("rst_rom_addr", rom_addr_h, 0);
        chk("rst_rom_cs", rom_cs_h, 0);
        chk("rst_din", din_h, 0);
        chk("rst_dec_rst", dec_rst_h, 0);
        chk("rst_busy", busy_h, 0);
        chk("rst_done", done_h, 0);
        chk("rst_underrun", underrun_h, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Stop and start together mid-play
        clear_counts();
        rom_delay = 2; tick_period = 0;
        start_addr = 16'h0040; end_addr = 16'h0045; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        fin = 1'b0;
        for (int c = 0; c < 50 && !fin; c++) begin
            @(posedge clk); #1;
            if (!rom_cs_h) fin = 1'b1;
        end
        chk("reached_play", fin, 1);
        cen = 1'b0; sample_man = 1'b1;
        @(posedge clk); #1 sample_man = 1'b0; cen = 1'b1;
        @(posedge clk); #1;
        chk("cen_low_ignored_hi", din_h, 4'hB);
        chk("cen_low_ignored_lo", din_l, 4'h6);
        exp_h.push_back(4'h1); exp_l.push_back(4'hA);
        sample_man = 1'b1;
        @(posedge clk); #1 sample_man = 1'b0;
        @(posedge clk); #1;
        chk("manual_tick_din", din_h, 4'h1);
        stop = 1'b1; start = 1'b1; start_addr = 16'h0070;
        @(posedge clk); #1 stop = 1'b0; start = 1'b0;
        chk("stop_busy", busy_h, 0);
        chk("stop_rom_cs", rom_cs_h, 0);
        chk("stop_no_dec_rst", dec_rst_h, 0);
        tick_cnt = 0; tick_period = 5;
        repeat (20) @(posedge clk);
        #1 tick_period = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("stop_no_done", done_cnt_h, 0);
        chk("idle_no_underrun", under_cnt_h, 0);
        chk("stop_din_held", din_h, 4'h1);
        chk("stop_nibbles_left", exp_h.size(), 0);
        start_addr = 16'h0050; end_addr = 16'h0050; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("restart_dec_rst", dec_rst_h, 1);
        chk("restart_rom_addr", rom_addr_h, 16'h0050);
        chk("restart_busy", busy_h, 1);
        @(posedge clk); #1;
        chk("restart_dec_rst_clear", dec_rst_h, 0);
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        chk("stop2_busy", busy_h, 0);
        exp_h.delete(); exp_l.delete();

        // Asynchronous reset during an outstanding fetch
        clear_counts();
        rom_delay = 50;
        start_addr = 16'h0060; end_addr = 16'h0061; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_reset_rom_cs", rom_cs_h, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_rom_cs", rom_cs_h, 0);
        chk("async_rst_busy", busy_h, 0);
        chk("async_rst_rom_addr", rom_addr_h, 0);
        chk("async_rst_din", din_h, 0);
        chk("async_rst_busy_lo", busy_l, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick_cnt = 0; tick_period = 10;
        repeat (100) @(posedge clk);
        #1 tick_period = 0;
        chk("post_reset_no_done", done_cnt_h + done_cnt_l, 0);
        chk("post_reset_busy", busy_h, 0);
        chk("post_reset_rom_cs", rom_cs_h, 0);
        chk("post_reset_underrun", under_cnt_h, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jt5205_player.md
JT5205_PLAYER -- requirements
Module: jt5205_player

Interface
REQ-001 SHALL have parameter AW, default 16, ROM address width.
REQ-002 SHALL have parameter HIGH_FIRST, default 1, where 1 = high nibble of each byte played first and 0 = low nibble first.
REQ-003 SHALL have port clk, input, 1, system clock (single clock domain).
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port cen, input, 1, clock enable qualifying sample.
REQ-006 SHALL have port sample, input, 1, sample-tick strobe from the timing block (cen_lo); acted on only when cen=1.
REQ-007 SHALL have port start, input, 1, one-cycle request to begin playback.
REQ-008 SHALL have port stop, input, 1, one-cycle request to abort playback.
REQ-009 SHALL have port start_addr, input, AW, first byte address; sampled on start.
REQ-010 SHALL have port end_addr, input, AW, last byte address, inclusive; sampled on start.
REQ-011 SHALL have port rom_addr, output, AW, ROM byte address.
REQ-012 SHALL have port rom_cs, output, 1, ROM read request.
REQ-013 SHALL have port rom_data, input, 8, ROM read data.
REQ-014 SHALL have port rom_ok, input, 1, rom_data valid for the current rom_addr while rom_cs=1.
REQ-015 SHALL have port din, output, 4, ADPCM nibble to the decoder.
REQ-016 SHALL have port dec_rst, output, 1, one-cycle decoder predictor clear.
REQ-017 SHALL have port busy, output, 1, playback active.
REQ-018 SHALL have port done, output, 1, one-cycle pulse at normal end of sample.
REQ-019 SHALL have port underrun, output, 1, one-cycle pulse when a tick finds no byte buffered.

Function
REQ-020 SHALL implement states IDLE, FETCH (rom_cs=1, waiting rom_ok) and PLAY (byte buffered, rom_cs=0).
REQ-021 SHALL, in any state on a cycle with start=1 and stop=0, latch start_addr and end_addr, set rom_addr=start_addr, and enter FETCH with busy=1 and dec_rst=1 for exactly the following cycle; this restarts playback if already busy.
REQ-022 SHALL, on stop=1 (stop wins over a simultaneous start), enter IDLE next cycle with rom_cs=0 and busy=0, leave din unchanged, and not pulse done.
REQ-023 SHALL, in FETCH on rom_cs=1 and rom_ok=1, latch rom_data into a one-byte buffer, set the nibble pointer to the first nibble per HIGH_FIRST, drop rom_cs next cycle, and enter PLAY.
REQ-024 SHALL hold rom_addr stable while rom_cs=1.
REQ-025 SHALL ignore rom_ok when rom_cs=0.
REQ-026 SHALL, in PLAY on cen&sample, load din with the current nibble, visible the cycle after the tick.
REQ-027 SHALL, after the first nibble is loaded, advance the pointer to the second nibble.
REQ-028 SHALL, after the second nibble is loaded with rom_addr!=end_addr, set rom_addr=rom_addr+1 modulo 2^AW and enter FETCH.
REQ-029 SHALL, after the second nibble is loaded with rom_addr==end_addr, enter IDLE, drop busy, and pulse done the same cycle that busy falls.
REQ-030 SHALL, on a cen&sample tick while in FETCH, leave din unchanged, pulse underrun for one cycle, and continue the fetch; the missed tick is not replayed.
REQ-031 SHALL, when end_addr<start_addr, wrap rom_addr through 2^AW-1 to 0 and stop at end_addr.
REQ-032 SHALL play exactly one byte (two nibbles) when end_addr==start_addr.
REQ-033 SHALL ignore sample while in IDLE and produce no underrun there.
REQ-034 SHALL, on a rom_ok and a tick in the same FETCH cycle, latch the byte and pulse underrun, with the nibble played on the next tick.

Reset
REQ-035 SHALL, while rst_n=0, force state=IDLE, rom_addr=0, rom_cs=0, din=0, dec_rst=0, busy=0, done=0, underrun=0, and an empty buffer.
REQ-036 SHALL, on reset asserted mid-playback, abandon any outstanding ROM request and never emit done.

Verification
REQ-037 SHALL cover: start_addr=0x0010, end_addr=0x0011, ROM bytes 0xA5 then 0x3C, rom_ok 2 cycles after rom_cs, ticks every 96 cen -> din sequence A,5,3,C; done one pulse after C; busy low after it; no underrun.
REQ-038 SHALL cover: HIGH_FIRST=0 with the same stimulus -> din sequence 5,A,C,3.
REQ-039 SHALL cover: rom_ok delayed 200 cycles with a tick every 96 cycles -> underrun pulses on ticks inside the wait; din holds its previous value; playback resumes correctly.
REQ-040 SHALL cover: start_addr=0xFFFF, end_addr=0x0000 -> rom_addr sequence 0xFFFF then 0x0000; four nibbles; then done.
REQ-041 SHALL cover: stop and start in the same cycle mid-play -> IDLE next cycle, rom_cs=0, no done; a later start yields dec_rst one cycle and rom_addr=start_addr.
REQ-042 SHALL cover: rst_n low while rom_cs=1 -> all outputs return to reset values asynchronously; no done after release.
